// File: rtl/fft_job_arbiter.sv
// -----------------------------------------------------------------------------
// fft_job_arbiter
//
// Arbitrates two requesters for a single in-place FFT core and sequences
// each job. The core is reset first, which clears its sticky done flag.
// The core is then started, and completion is watched under a watchdog.
// The block returns a per-requester ack or err pulse plus the job's RUN
// cycle count.
//
// Ports:
//   clk_i          - single clock, rising edge
//   reset_i        - synchronous active-high reset
//   req_i[1:0]     - level requests, bit i = requester i
//   grant_o[1:0]   - one-hot grant, high from CLR through end of RUN/ABORT
//   sel_o          - index of current/last granted requester
//   ack_o[1:0]     - one-cycle completion pulse on ack_o[sel_o]
//   err_o[1:0]     - one-cycle timeout pulse on err_o[sel_o]
//   busy_o         - high whenever the sequencer is not IDLE
//   fft_reset_o    - core synchronous reset (top level ORs with reset)
//   fft_start_o    - core start pulse
//   fft_done_i     - core done, level, sticky until core reset
//   last_cycles_o  - RUN cycle count of the last successfully completed job
// -----------------------------------------------------------------------------
module fft_job_arbiter #(
    parameter int TIMEOUT = 16384,
    parameter int CNT_W   = 15
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [1:0]       req_i,
    output logic [1:0]       grant_o,
    output logic             sel_o,
    output logic [1:0]       ack_o,
    output logic [1:0]       err_o,
    output logic             busy_o,
    output logic             fft_reset_o,
    output logic             fft_start_o,
    input  logic             fft_done_i,
    output logic [CNT_W-1:0] last_cycles_o
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_START = 3'd2,
        ST_RUN   = 3'd3,
        ST_ABORT = 3'd4
    } state_e;

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic              rr_q, rr_d;
    logic [1:0]        grant_q, grant_d;
    logic              sel_q, sel_d;
    logic [1:0]        ack_q, ack_d;
    logic [1:0]        err_q, err_d;
    logic              busy_q, busy_d;
    logic              fft_reset_q, fft_reset_d;
    logic              fft_start_q, fft_start_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  last_q, last_d;
    logic              winner_s;
    logic [1:0]        sel_onehot_s;

    // The round-robin pointer wins when it is requesting; otherwise the other requester wins.
    assign winner_s     = req_i[rr_q] ? rr_q : ~rr_q;
    assign sel_onehot_s = sel_q ? 2'b10 : 2'b01;

    // Next-state and registered-output decode for the job sequencer.
    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        grant_d     = grant_q;
        sel_d       = sel_q;
        ack_d       = 2'b00;
        err_d       = 2'b00;
        fft_reset_d = 1'b0;
        fft_start_d = 1'b0;
        cnt_d       = cnt_q;
        last_d      = last_q;

        case (state_q)
            ST_IDLE: begin
                if (req_i != 2'b00) begin
                    sel_d       = winner_s;
                    grant_d     = winner_s ? 2'b10 : 2'b01;
                    // Resetting the core on CLR entry clears any stale done.
                    fft_reset_d = 1'b1;
                    state_d     = ST_CLR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLR: begin
                fft_start_d = 1'b1;
                state_d     = ST_START;
            end
            ST_START: begin
                cnt_d   = {CNT_W{1'b0}};
                state_d = ST_RUN;
            end
            ST_RUN: begin
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                // When done and the timeout coincide, the job still counts as completed.
                if (fft_done_i) begin
                    last_d  = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    ack_d   = sel_onehot_s;
                    grant_d = 2'b00;
                    rr_d    = ~sel_q;
                    state_d = ST_IDLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    err_d       = sel_onehot_s;
                    fft_reset_d = 1'b1;
                    state_d     = ST_ABORT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_ABORT: begin
                grant_d = 2'b00;
                rr_d    = ~sel_q;
                state_d = ST_IDLE;
            end
            default: begin
                grant_d = 2'b00;
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset leaves the core held in reset for one more cycle.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            rr_q        <= 1'b0;
            grant_q     <= 2'b00;
            sel_q       <= 1'b0;
            ack_q       <= 2'b00;
            err_q       <= 2'b00;
            busy_q      <= 1'b0;
            fft_reset_q <= 1'b1;
            fft_start_q <= 1'b0;
            cnt_q       <= {CNT_W{1'b0}};
            last_q      <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            grant_q     <= grant_d;
            sel_q       <= sel_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            fft_reset_q <= fft_reset_d;
            fft_start_q <= fft_start_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
        end
    end

    assign grant_o       = grant_q;
    assign sel_o         = sel_q;
    assign ack_o         = ack_q;
    assign err_o         = err_q;
    assign busy_o        = busy_q;
    assign fft_reset_o   = fft_reset_q;
    assign fft_start_o   = fft_start_q;
    assign last_cycles_o = last_q;

endmodule

// File: tb/tb_fft_job_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fft_job_arbiter
//
// Directed bench for fft_job_arbiter with TIMEOUT=8. Inputs change 1 ns after
// each rising edge, and outputs are checked at the same point.
// -----------------------------------------------------------------------------
module tb_fft_job_arbiter;

    localparam int CNT_W = 15;

    logic             clk;
    logic             reset;
    logic [1:0]       req;
    logic [1:0]       grant;
    logic             sel;
    logic [1:0]       ack;
    logic [1:0]       err;
    logic             busy;
    logic             fft_reset;
    logic             fft_start;
    logic             fft_done;
    logic [CNT_W-1:0] last_cycles;

    int total_checks;
    int passed_checks;

    fft_job_arbiter #(.TIMEOUT(8), .CNT_W(CNT_W)) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .req_i         (req),
        .grant_o       (grant),
        .sel_o         (sel),
        .ack_o         (ack),
        .err_o         (err),
        .busy_o        (busy),
        .fft_reset_o   (fft_reset),
        .fft_start_o   (fft_start),
        .fft_done_i    (fft_done),
        .last_cycles_o (last_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs and checks happen 1 ns after the edge.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_checks++;
        assert (obs === exp) passed_checks++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Compact check of the handshake outputs.
    task automatic check_ctl(input string tag, input logic [1:0] g, input logic b,
                             input logic fr, input logic fs, input logic [1:0] a,
                             input logic [1:0] e);
        check({tag, ".grant"},     32'(grant),     32'(g));
        check({tag, ".busy"},      32'(busy),      32'(b));
        check({tag, ".fft_reset"}, 32'(fft_reset), 32'(fr));
        check({tag, ".fft_start"}, 32'(fft_start), 32'(fs));
        check({tag, ".ack"},       32'(ack),       32'(a));
        check({tag, ".err"},       32'(err),       32'(e));
    endtask

    initial begin
        total_checks  = 0;
        passed_checks = 0;
        reset    = 1'b1;
        req      = 2'b00;
        fft_done = 1'b0;

        // ---------------- reset state ----------------
        tick(2);
        check_ctl("rst", 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
        check("rst.sel",  32'(sel), 32'd0);
        check("rst.last", 32'(last_cycles), 32'd0);
        reset = 1'b0;
        tick();
        check("rst.release_fft_reset", 32'(fft_reset), 32'd0);

        // ---------------- single job, done in RUN cycle 5 ----------------
        req = 2'b01;
        tick();                                     // CLR
        check_ctl("sj.clr", 2'b01, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00);
        check("sj.sel", 32'(sel), 32'd0);
        req = 2'b00;
        tick();                                     // START
        check_ctl("sj.start", 2'b01, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00);
        tick();                                     // RUN1
        check_ctl("sj.run1", 2'b01, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
        tick(4);                                    // RUN5
        fft_done = 1'b1;
        tick();                                     // ack cycle (IDLE)
        check_ctl("sj.ack", 2'b00, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00);
        check("sj.last", 32'(last_cycles), 32'd5);
        fft_done = 1'b0;
        tick();
        check("sj.ack_pulse_end", 32'(ack), 32'd0);

        // ---------------- round robin from a fresh rr=0 ----------------
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req   = 2'b11;
        begin
            logic [1:0] exp_g [4];
            exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
            for (int j = 0; j < 4; j++) begin
                tick();                             // CLR
                check($sformatf("rr%0d.grant", j), 32'(grant), 32'(exp_g[j]));
                tick(2);                            // START, RUN1
                fft_done = 1'b1;
                tick();                             // ack cycle
                check($sformatf("rr%0d.ack", j), 32'(ack), 32'(exp_g[j]));
                check($sformatf("rr%0d.last", j), 32'(last_cycles), 32'd1);
                fft_done = 1'b0;
            end
        end
        req = 2'b00;
        tick();
        check("rr.idle_busy", 32'(busy), 32'd0);

        // ---------------- timeout (core never done) ----------------
        req = 2'b01;
        tick();                                     // CLR
        check("to.grant", 32'(grant), 32'd1);
        req = 2'b00;
        tick(2);                                    // START, RUN1
        tick(7);                                    // RUN8
        check_ctl("to.run8", 2'b01, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
        tick();                                     // ABORT
        check_ctl("to.abort", 2'b01, 1'b1, 1'b1, 1'b0, 2'b00, 2'b01);
        check("to.last_kept", 32'(last_cycles), 32'd1);
        tick();                                     // IDLE
        check_ctl("to.idle", 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);

        // ---------------- done coincides with timeout (requester 1) ----------------
        req = 2'b10;
        tick();                                     // CLR
        check("dt.grant", 32'(grant), 32'd2);
        check("dt.sel",   32'(sel),   32'd1);
        req = 2'b00;
        tick(2);                                    // START, RUN1
        tick(7);                                    // RUN8
        fft_done = 1'b1;
        tick();
        check_ctl("dt.ack", 2'b00, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00);
        check("dt.last", 32'(last_cycles), 32'd8);

        // ---------------- sticky done from previous job ----------------
        // fft_done is still high; the model core clears it once reset in CLR.
        req = 2'b01;
        tick();                                     // CLR, done still high
        check_ctl("sd.clr", 2'b01, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00);
        req      = 2'b00;
        tick();                                     // START, core now cleared
        fft_done = 1'b0;
        check("sd.start_noack", 32'(ack), 32'd0);
        tick(3);                                    // RUN3
        check_ctl("sd.run3", 2'b01, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
        fft_done = 1'b1;
        tick();
        check("sd.ack",  32'(ack), 32'd1);
        check("sd.last", 32'(last_cycles), 32'd3);
        fft_done = 1'b0;
        tick();

        // ---------------- reset mid-RUN ----------------
        req = 2'b10;
        tick();                                     // CLR
        check("rm.grant", 32'(grant), 32'd2);
        tick(4);                                    // START, RUN1..RUN3
        reset = 1'b1;
        tick();
        check_ctl("rm.reset", 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
        check("rm.sel",  32'(sel), 32'd0);
        check("rm.last", 32'(last_cycles), 32'd0);
        reset = 1'b0;
        req   = 2'b00;
        tick();
        check_ctl("rm.release", 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        req = 2'b11;
        tick();                                     // CLR, rr back to 0
        check("rm.regrant", 32'(grant), 32'd1);
        req = 2'b00;
        tick(2);                                    // START, RUN1
        fft_done = 1'b1;
        tick();
        check("rm.ack",  32'(ack), 32'd1);
        check("rm.last", 32'(last_cycles), 32'd1);
        fft_done = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
